// File: rtl/kbd_spi_matrix.sv
// kbd_spi_matrix: SPI-slave receiver for the 48-bit keyboard/joystick frame feeding the ZX port #FE key matrix and Kempston port #1F.
// Optional build macro KBD_WATCHDOG_EN adds a no-frame timeout that releases all keys and clears the joystick.
module kbd_spi_matrix #(
  parameter int FRAME_BITS = 48
`ifdef KBD_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 1400000
`endif
) (
  input  logic       CLK_14MHZ,
  input  logic       CPU_RESET,
  input  logic       KBD_CLK,
  input  logic       KBD_CS,
  input  logic       KBD_DI,
  input  logic [7:0] A_HI,
  output logic [4:0] KD,
  output logic [7:0] JOY,
  output logic       FRAME_STROBE,
  output logic       FRAME_ERR
);
  logic [2:0]            clk_sync_q, cs_sync_q;
  logic [1:0]            di_sync_q;
  logic                  clk_rise, cs_fall, cs_rise, commit, wd_clr;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [39:0]           mat_q, mat_d;
  logic [7:0]            joy_q, joy_d;
  logic                  strobe_q, err_q;

  // Two-flop synchronisers on all SPI pins; the third CLK/CS flop is the edge-detect history
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      clk_sync_q <= 3'b000;
      cs_sync_q  <= 3'b111;
      di_sync_q  <= 2'b00;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], KBD_CLK};
      cs_sync_q  <= {cs_sync_q[1:0], KBD_CS};
      di_sync_q  <= {di_sync_q[0], KBD_DI};
    end
  end

  // A clock rise counts only while CS is low in the synchronised domain, so a coincident CS rise masks it
  assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2] & ~cs_sync_q[1];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign commit   = cs_rise & (cnt_q == 6'(FRAME_BITS));

`ifdef KBD_WATCHDOG_EN
  logic [20:0] wd_q, wd_d;
  logic        wd_hit;
  assign wd_hit = wd_q == 21'(TIMEOUT_CYCLES);
  assign wd_clr = wd_hit & ~commit;
  // Watchdog counts cycles since the last commit and parks at the limit
  always_comb wd_d = commit ? 21'd0 : wd_hit ? wd_q : wd_q + 21'd1;
  // Watchdog register
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) wd_q <= 21'd0;
    else wd_q <= wd_d;
  end
`else
  assign wd_clr = 1'b0;
`endif

  // Shift new bits in at the top so the first received bit ends up at index 0; commit inverts into the active-low matrix
  always_comb begin
    shift_d = clk_rise ? {di_sync_q[1], shift_q[FRAME_BITS-1:1]} : shift_q;
    cnt_d   = cs_fall ? 6'd0 : (clk_rise && cnt_q != 6'd63) ? cnt_q + 6'd1 : cnt_q;
    mat_d   = commit ? ~shift_q[39:0] : wd_clr ? '1 : mat_q;
    joy_d   = commit ? shift_q[40 +: 8] : wd_clr ? 8'h00 : joy_q;
  end

  // Frame state registers and the one-cycle commit/discard pulses
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      shift_q  <= '0;
      cnt_q    <= 6'd0;
      mat_q    <= '1;
      joy_q    <= 8'h00;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      mat_q    <= mat_d;
      joy_q    <= joy_d;
      strobe_q <= commit;
      err_q    <= cs_rise & ~commit;
    end
  end

  // Each low address line selects a half-row; selected rows AND together column by column
  always_comb begin
    KD = 5'h1F;
    for (int r = 0; r < 8; r++) KD = A_HI[r] ? KD : KD & mat_q[r*5 +: 5];
  end

  assign JOY          = joy_q;
  assign FRAME_STROBE = strobe_q;
  assign FRAME_ERR    = err_q;
endmodule

// File: tb/tb_kbd_spi_matrix.sv
// tb_kbd_spi_matrix: directed frames against a key-press model of the ZX matrix and Kempston byte
`timescale 1ns/1ps
module tb_kbd_spi_matrix;
  logic       clk = 1'b0, rst_n = 1'b0, kclk = 1'b0, kcs = 1'b1, kdi = 1'b0;
  logic [7:0] a_hi = 8'hFF;
  logic [4:0] kd;
  logic [7:0] joy;
  logic       strobe, err;
  int         checks = 0, errors = 0;
  bit         pressed [40];
  logic [7:0] m_joy = 8'h00;
  bit         check_en = 1'b0;
  logic [63:0] v;

  always #35 clk = ~clk;

  kbd_spi_matrix #(
    .FRAME_BITS(48)
`ifdef KBD_WATCHDOG_EN
    , .TIMEOUT_CYCLES(1000)
`endif
  ) dut (
    .CLK_14MHZ(clk), .CPU_RESET(rst_n), .KBD_CLK(kclk), .KBD_CS(kcs), .KBD_DI(kdi),
    .A_HI(a_hi), .KD(kd), .JOY(joy), .FRAME_STROBE(strobe), .FRAME_ERR(err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A column reads 0 when any key in that column of any selected row is held
  function automatic logic [4:0] model_kd(logic [7:0] a);
    logic [4:0] k;
    k = 5'h1F;
    for (int n = 0; n < 40; n++) if (!a[n/5] && pressed[n]) k[n%5] = 1'b0;
    return k;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic model_release();
    for (int n = 0; n < 40; n++) pressed[n] = 1'b0;
    m_joy = 8'h00;
  endtask

  // 3.5 MHz SPI bit: two system cycles low, two high
  task automatic spi_bit(bit b);
    kdi = b;
    tick(2);
    kclk = 1'b1;
    tick(2);
    kclk = 1'b0;
  endtask

  task automatic cs_low();
    kcs = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(logic [63:0] d, int from, int to);
    for (int i = from; i < to; i++) spi_bit(d[i]);
  endtask

  // Raise CS and expect exactly one strobe or error pulse within 4 cycles
  task automatic cs_high(bit exp_commit, logic [63:0] d);
    int s, e, lat;
    s = 0; e = 0; lat = -1;
    tick(2);
    check_en = 1'b0;
    kcs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((strobe || err) && lat < 0) lat = i;
      s += int'(strobe);
      e += int'(err);
    end
    chk("strobe_count", s, exp_commit ? 1 : 0);
    chk("err_count", e, exp_commit ? 0 : 1);
    chk("pulse_within_4", (lat >= 0 && lat < 4) ? 1 : 0, 1);
    if (exp_commit) begin
      for (int n = 0; n < 40; n++) pressed[n] = d[n];
      m_joy = d[47:40];
    end
    tick(1);
    check_en = 1'b1;
  endtask

  task automatic frame(logic [63:0] d, int nbits, bit exp_commit);
    cs_low();
    send_bits(d, 0, nbits);
    cs_high(exp_commit, d);
  endtask

  always @(negedge clk) if (check_en) begin
    chk("kd_model", kd, model_kd(a_hi));
    chk("joy_model", joy, m_joy);
    chk("strobe_idle", strobe, 0);
    chk("err_idle", err, 0);
  end

  initial begin
    model_release();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_en = 1'b1;
    a_hi = 8'hFE; tick(1); chk("rst_kd_fe", kd, 5'h1F);
    a_hi = 8'hFF; tick(1); chk("rst_kd_ff", kd, 5'h1F);
    chk("rst_joy", joy, 8'h00);
    tick(20);

    v = '0; v[0] = 1'b1; v[44] = 1'b1;
    frame(v, 48, 1'b1);
    a_hi = 8'hFE; tick(2); chk("caps_kd_fe", kd, 5'b11110);
    a_hi = 8'hFD; tick(2); chk("caps_kd_fd", kd, 5'h1F);
    chk("fire_joy", joy, 8'h10);

    v = '0; v[7] = 1'b1; v[37] = 1'b1;
    frame(v, 48, 1'b1);
    a_hi = 8'h7D; tick(2); chk("dm_kd_7d", kd, 5'b11011);
    a_hi = 8'h7F; tick(2); chk("dm_kd_7f", kd, 5'b11011);
    a_hi = 8'hFB; tick(2); chk("dm_kd_fb", kd, 5'h1F);
    chk("dm_joy", joy, 8'h00);

    v = '0; v[0] = 1'b1; v[40] = 1'b1;
    frame(v, 48, 1'b1);
    chk("right_joy", joy, 8'h01);
    v = '1;
    frame(v, 47, 1'b0);
    frame(v, 49, 1'b0);
    a_hi = 8'hFE; tick(2); chk("short_long_kd", kd, 5'b11110);
    chk("short_long_joy", joy, 8'h01);

    v = '0; v[35] = 1'b1;
    cs_low();
    send_bits(v, 0, 20);
    check_en = 1'b0;
    rst_n = 1'b0;
    model_release();
    spi_bit(v[20]);
    rst_n = 1'b1;
    tick(1);
    check_en = 1'b1;
    send_bits(v, 21, 48);
    cs_high(1'b0, v);
    a_hi = 8'h7F; tick(2); chk("reset_space_kd", kd, 5'h1F);
    chk("reset_joy", joy, 8'h00);

    v = '0; v[30] = 1'b1;
    frame(v, 48, 1'b1);
    a_hi = 8'hBF; tick(2); chk("enter_kd", kd, 5'b11110);
    check_en = 1'b0;
    tick(890); chk("enter_kd_held", kd, 5'b11110);
    tick(200);
`ifdef KBD_WATCHDOG_EN
    chk("enter_kd_timeout", kd, 5'h1F);
`else
    chk("enter_kd_forever", kd, 5'b11110);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
